branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Produces the `pred_taken`/`pc_pred` pair consumed by the fetch next-PC mux.
- Lookup is combinational on the fetch PC, so a prediction steers the next PC in the same cycle.
- Trained from execute with the resolved outcome of every control-flow instruction. Invalidated wholesale on `inv_all` (fence.i / context change).

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, min 2.
- IDX_BITS, $clog2(ENTRIES), index width (derived, not overridable).
- TAG_BITS, 30-IDX_BITS, tag width (derived).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_f  input  32  fetch-stage PC to look up.
- pred_taken  output  1  predict taken for pc_f.
- pc_pred  output  32  predicted target for pc_f.
- pred_hit  output  1  pc_f matches a valid entry (debug/perf).
- upd_valid  input  1  execute reports a resolved branch/jump this cycle.
- upd_pc  input  32  PC of the resolved instruction.
- upd_taken  input  1  resolved direction.
- upd_target  input  32  resolved taken target.
- inv_all  input  1  clear all valid bits.

Behaviour:
- Address split: idx = pc[IDX_BITS+1:2], tag = pc[31:IDX_BITS+2]; pc[1:0] ignored.
- Per entry: valid (1), tag (TAG_BITS), target (32), ctr (2): 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup, combinational, zero latency:
  - hit = valid[idx] && tag[idx]==tag(pc_f).
  - pred_hit = hit.
  - pred_taken = hit && ctr[idx][1].
  - pc_pred = target[idx] when hit; 32'b0 otherwise.
- Update, registered on the clk edge when upd_valid=1:
  - Update hit, taken: ctr saturating increment (11 stays 11); target <= upd_target.
  - Update hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Update miss, taken: allocate. valid=1, tag, target=upd_target, ctr=10 (WT). Unconditionally replaces whatever entry sits at idx.
  - Update miss, not taken: no state change; no allocation.
- Read/write same index same cycle: lookup returns pre-update state (no bypass). New state visible from the next cycle.
- inv_all=1:
  - All valid bits cleared at the edge; tag/target/ctr retain contents.
  - Overrides a simultaneous upd_valid, i.e. no allocation that cycle.
  - Lookup in the same cycle still uses old valid bits.
- Reset (asynchronous, any time, including mid-update):
  - All valid <= 0; all ctr <= 01; tag/target need no reset.
  - Outputs during/after reset: pred_taken=0, pred_hit=0, pc_pred=0.
- No X propagation: tag/target of invalid entries never reach outputs (pc_pred gated by hit).
- Aliasing: two PCs with same idx, different tag thrash. Last taken allocation wins.
- No internal stall handling; the fetch stage holds pc_f stable when stalled, and repeated lookup is side-effect free.

Test Plan:
- Reset then lookup pc_f=0x0000_0040 -> pred_hit=0, pred_taken=0, pc_pred=0.
- upd pc=0x0000_0040 taken target=0x0000_0100, next cycle lookup 0x40 -> pred_hit=1, pred_taken=1 (ctr=10), pc_pred=0x100.
- Then two not-taken updates to 0x40 -> ctr 10→01→00: pred_taken=0 after the first, pred_hit stays 1. Two further taken updates -> ctr 01, 10, pred_taken=1 again. Four taken updates from 10 -> saturates at 11.
- Alias: allocate 0x40→0x100, then taken update 0x80 (same idx for ENTRIES=16, different tag) target 0x200 -> lookup 0x40 pred_hit=0; lookup 0x80 pc_pred=0x200.
- Same-cycle: lookup 0x40 while allocating 0x40 -> pred_hit=0 that cycle, 1 next cycle. inv_all with taken update to 0x60 -> next cycle lookups 0x40 and 0x60 both miss.
- Assert reset asynchronously between clock edges after populating 4 entries -> outputs go 0 before the next edge. After release, all four PCs miss; first taken update re-allocates with ctr=10.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor_if
// Description : Fetch-side lookup and execute-side training bundle for the
//               branch target predictor.
//               Lookup  : pc_f -> pred_taken, pc_pred, pred_hit
//               Training: upd_valid, upd_pc, upd_taken, upd_target
//               Control : inv_all (clear all valid bits)
//               The master modport belongs to the core (fetch/execute). The
//               slave modport belongs to the predictor.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_target_predictor_if;
   logic        pc_f_lookup_unused_guard;
   logic [31:0] pc_f;
   logic        pred_taken;
   logic [31:0] pc_pred;
   logic        pred_hit;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        inv_all;

   modport master (
      output pc_f,
      input  pred_taken,
      input  pc_pred,
      input  pred_hit,
      output upd_valid,
      output upd_pc,
      output upd_taken,
      output upd_target,
      output inv_all
   );

   modport slave (
      input  pc_f,
      output pred_taken,
      output pc_pred,
      output pred_hit,
      input  upd_valid,
      input  upd_pc,
      input  upd_taken,
      input  upd_target,
      input  inv_all
   );
endinterface
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor
// Description : Direct-mapped branch target buffer with a 2-bit saturating
//               direction counter per entry. The lookup is combinational on
//               the fetch PC. Training happens at the clock edge from the
//               resolved outcome reported by execute.
// Ports       : clk   - core clock, rising edge
//               reset - asynchronous, active-high reset
//               bus   - slave side of branch_target_predictor_if
//                       (lookup, training and invalidate signals)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor #(
   parameter int ENTRIES = 16
) (
   input  wire logic                clk,
   input  wire logic                reset,
   branch_target_predictor_if.slave bus
);

   localparam int IDX_BITS = $clog2(ENTRIES);
   localparam int TAG_BITS = 30 - IDX_BITS;

   localparam logic [1:0] c_CTR_SNT = 2'b00;
   localparam logic [1:0] c_CTR_WNT = 2'b01;
   localparam logic [1:0] c_CTR_WT  = 2'b10;
   localparam logic [1:0] c_CTR_ST  = 2'b11;

   // Only valid and ctr need reset. Tag and target are never observed
   // through an invalid entry, because every output is gated by hit.
   logic [ENTRIES-1:0]        valid_q, valid_d;
   logic [ENTRIES-1:0][1:0]   ctr_q,   ctr_d;
   logic [TAG_BITS-1:0]       tag_q    [ENTRIES];
   logic [31:0]               target_q [ENTRIES];

   // ---------------------------------------------------------------- lookup
   logic [IDX_BITS-1:0] w_look_idx;
   logic [TAG_BITS-1:0] w_look_tag;
   logic                w_look_hit;

   assign w_look_idx = bus.pc_f[IDX_BITS+1:2];
   assign w_look_tag = bus.pc_f[31:IDX_BITS+2];
   assign w_look_hit = valid_q[w_look_idx] && (tag_q[w_look_idx] == w_look_tag);

   assign bus.pred_hit   = w_look_hit;
   assign bus.pred_taken = w_look_hit && ctr_q[w_look_idx][1];
   assign bus.pc_pred    = w_look_hit ? target_q[w_look_idx] : 32'h0000_0000;

   // Instruction alignment bits do not take part in indexing or tagging.
   logic w_unused_lsbs;
   assign w_unused_lsbs = ^{bus.pc_f[1:0], bus.upd_pc[1:0]};

   // ---------------------------------------------------------------- update
   logic [IDX_BITS-1:0] w_upd_idx;
   logic [TAG_BITS-1:0] w_upd_tag;
   logic                w_upd_hit;
   logic                w_wr_entry;

   assign w_upd_idx = bus.upd_pc[IDX_BITS+1:2];
   assign w_upd_tag = bus.upd_pc[31:IDX_BITS+2];
   assign w_upd_hit = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);

   // A taken outcome rewrites tag and target. On a hit, the tag write
   // stores the same value. On a miss, the write is the allocation.
   // inv_all takes priority, so nothing is written in that cycle.
   assign w_wr_entry = bus.upd_valid && bus.upd_taken && !bus.inv_all;

   always_comb begin
      valid_d = valid_q;
      ctr_d   = ctr_q;
      if (bus.inv_all) begin
         valid_d = '0;
      end else if (bus.upd_valid) begin
         if (w_upd_hit) begin
            if (bus.upd_taken) begin
               if (ctr_q[w_upd_idx] != c_CTR_ST)
                  ctr_d[w_upd_idx] = ctr_q[w_upd_idx] + 2'd1;
            end else begin
               if (ctr_q[w_upd_idx] != c_CTR_SNT)
                  ctr_d[w_upd_idx] = ctr_q[w_upd_idx] - 2'd1;
            end
         end else if (bus.upd_taken) begin
            valid_d[w_upd_idx] = 1'b1;
            ctr_d[w_upd_idx]   = c_CTR_WT;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         ctr_q   <= {ENTRIES{c_CTR_WNT}};
      end else begin
         valid_q <= valid_d;
         ctr_q   <= ctr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_entry) begin
         tag_q[w_upd_idx]    <= w_upd_tag;
         target_q[w_upd_idx] <= bus.upd_target;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_predictor
// Description : Directed test of branch_target_predictor with hand-computed
//               expected lookup results ({pred_hit, pred_taken, pc_pred}).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   branch_target_predictor_if bp ();

   branch_target_predictor #(.ENTRIES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bp.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [33:0] obs;
   assign obs = {bp.pred_hit, bp.pred_taken, bp.pc_pred};

   // Wait for the next rising edge and then move just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input logic [31:0] pc);
      bp.pc_f = pc;
      #1;
   endtask

   // Apply one training update for a single edge.
   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      bp.upd_valid  = 1'b1;
      bp.upd_pc     = pc;
      bp.upd_taken  = tk;
      bp.upd_target = tgt;
      step();
      bp.upd_valid  = 1'b0;
   endtask

   task automatic expect_obs(input string name, input logic [33:0] want);
      vectors++;
      if (obs !== want) begin
         miscompares++;
         $display("FAIL %s: got hit/tk/pc=%h want %h", name, obs, want);
      end
   endtask

   task automatic test_reset();
      look(32'h40);
      expect_obs("reset_lookup", {1'b0, 1'b0, 32'h0});
      step();
      reset = 1'b0;
      step();
      look(32'h40);
      expect_obs("post_reset_lookup", {1'b0, 1'b0, 32'h0});
   endtask

   task automatic test_alloc_same_cycle();
      bp.upd_valid  = 1'b1;
      bp.upd_pc     = 32'h40;
      bp.upd_taken  = 1'b1;
      bp.upd_target = 32'h100;
      look(32'h40);
      expect_obs("alloc_same_cycle", {1'b0, 1'b0, 32'h0});
      step();
      bp.upd_valid = 1'b0;
      look(32'h40);
      expect_obs("alloc_next_cycle", {1'b1, 1'b1, 32'h100});
   endtask

   task automatic test_counter();
      upd(32'h40, 1'b0, 32'hDEAD_BEE0);
      look(32'h40);
      expect_obs("ctr_01", {1'b1, 1'b0, 32'h100});
      upd(32'h40, 1'b0, 32'h0);
      look(32'h40);
      expect_obs("ctr_00", {1'b1, 1'b0, 32'h100});
      upd(32'h40, 1'b0, 32'h0);
      look(32'h40);
      expect_obs("ctr_00_sat", {1'b1, 1'b0, 32'h100});
      upd(32'h40, 1'b1, 32'h100);
      look(32'h40);
      expect_obs("ctr_up_01", {1'b1, 1'b0, 32'h100});
      upd(32'h40, 1'b1, 32'h100);
      look(32'h40);
      expect_obs("ctr_up_10", {1'b1, 1'b1, 32'h100});
      for (int i = 0; i < 4; i++) upd(32'h40, 1'b1, 32'h140);
      look(32'h40);
      expect_obs("ctr_11_new_target", {1'b1, 1'b1, 32'h140});
      // From 11, the first not-taken update must leave the prediction taken.
      upd(32'h40, 1'b0, 32'h0);
      look(32'h40);
      expect_obs("ctr_sat_then_10", {1'b1, 1'b1, 32'h140});
      upd(32'h40, 1'b0, 32'h0);
      look(32'h40);
      expect_obs("ctr_sat_then_01", {1'b1, 1'b0, 32'h140});
   endtask

   task automatic test_miss_not_taken();
      upd(32'h44, 1'b0, 32'h500);
      look(32'h44);
      expect_obs("miss_nt_no_alloc", {1'b0, 1'b0, 32'h0});
   endtask

   task automatic test_alias();
      upd(32'h40, 1'b1, 32'h100);
      upd(32'h80, 1'b1, 32'h200);
      look(32'h40);
      expect_obs("alias_evicted", {1'b0, 1'b0, 32'h0});
      look(32'h80);
      expect_obs("alias_winner", {1'b1, 1'b1, 32'h200});
   endtask

   task automatic test_inv_all();
      upd(32'h40, 1'b1, 32'h100);
      bp.inv_all    = 1'b1;
      bp.upd_valid  = 1'b1;
      bp.upd_pc     = 32'h60;
      bp.upd_taken  = 1'b1;
      bp.upd_target = 32'h600;
      look(32'h40);
      expect_obs("inv_same_cycle_old", {1'b1, 1'b1, 32'h100});
      step();
      bp.inv_all   = 1'b0;
      bp.upd_valid = 1'b0;
      look(32'h40);
      expect_obs("inv_clears_40", {1'b0, 1'b0, 32'h0});
      look(32'h60);
      expect_obs("inv_blocks_alloc_60", {1'b0, 1'b0, 32'h0});
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) upd(32'h40 + 32'(i * 4), 1'b1, 32'h1000 + 32'(i * 4));
      look(32'h48);
      expect_obs("populated_48", {1'b1, 1'b1, 32'h1008});
      // Assert reset mid-cycle while a taken update is pending.
      bp.upd_valid  = 1'b1;
      bp.upd_pc     = 32'h70;
      bp.upd_taken  = 1'b1;
      bp.upd_target = 32'h700;
      #2;
      reset = 1'b1;
      #1;
      expect_obs("async_reset_immediate", {1'b0, 1'b0, 32'h0});
      step();
      bp.upd_valid = 1'b0;
      reset = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         look(32'h40 + 32'(i * 4));
         expect_obs("after_reset_miss", {1'b0, 1'b0, 32'h0});
      end
      look(32'h70);
      expect_obs("reset_blocks_update", {1'b0, 1'b0, 32'h0});
      upd(32'h48, 1'b1, 32'h3000);
      look(32'h48);
      expect_obs("realloc_wt", {1'b1, 1'b1, 32'h3000});
      upd(32'h48, 1'b0, 32'h0);
      look(32'h48);
      expect_obs("realloc_then_wnt", {1'b1, 1'b0, 32'h3000});
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      reset         = 1'b1;
      bp.pc_f       = 32'h0;
      bp.upd_valid  = 1'b0;
      bp.upd_pc     = 32'h0;
      bp.upd_taken  = 1'b0;
      bp.upd_target = 32'h0;
      bp.inv_all    = 1'b0;
      #1;
      test_reset();
      test_alloc_same_cycle();
      test_counter();
      test_miss_not_taken();
      test_alias();
      test_inv_all();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
